// File: rtl/fwd_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard_pkg
//  Shared constants for the hazard/forwarding scoreboard.
//  - Result-kind codes (what a bypass value is): V (register file), PC, AO
//    (ALU out), MD (memory data), HL (HI/LO).
//  - FWD_SEL_RF: forwarding select meaning "take the register file value".
//  - Stage record field layout, youngest field last in the packed view:
//      {valid, wa[ADDR_W-1:0], tnew[TNEW_W-1:0], src[SRC_W-1:0]}
//    The top keeps each field in its own packed vector (stage 1 at slice 0)
//    so the per-port comparator can scan the stages without unpacking.
// ---------------------------------------------------------------------------
package fwd_scoreboard_pkg;

  localparam int unsigned SRC_V  = 0;
  localparam int unsigned SRC_PC = 1;
  localparam int unsigned SRC_AO = 2;
  localparam int unsigned SRC_MD = 3;
  localparam int unsigned SRC_HL = 4;

  localparam int unsigned FWD_SEL_RF = 0;

endpackage

// File: rtl/fwd_scoreboard_port_cmp.sv
// ---------------------------------------------------------------------------
// fwd_port_cmp
//  Compares one decode-stage read port against all DEPTH in-flight records.
//  The youngest matching stage (lowest index) wins.
//  Ports:
//    rec_vld/rec_wa/rec_tnew/rec_src  packed stage records, stage k at slice k-1
//    rd_addr, rd_used, rd_tuse        this port's read request
//    sel     0 = register file, k = stage k
//    src     result kind of the selected stage, V when sel = 0
//    rdy     selected value exists this cycle
//    hazard  match whose result arrives later than this port needs it
// ---------------------------------------------------------------------------
module fwd_port_cmp
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2,
  parameter int SRC_W  = 3,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]        rec_vld,
  input  logic [DEPTH*ADDR_W-1:0] rec_wa,
  input  logic [DEPTH*TNEW_W-1:0] rec_tnew,
  input  logic [DEPTH*SRC_W-1:0]  rec_src,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_used,
  input  logic [TNEW_W-1:0]       rd_tuse,
  output logic [SEL_W-1:0]        sel,
  output logic [SRC_W-1:0]        src,
  output logic                    rdy,
  output logic                    hazard
);

  logic              hit;
  logic [TNEW_W-1:0] hit_tnew;

  // Scan oldest to youngest so the last assignment is the youngest match.
  always_comb begin
    sel      = SEL_W'(FWD_SEL_RF);
    src      = SRC_W'(SRC_V);
    hit      = 1'b0;
    hit_tnew = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (rec_vld[k-1] && rd_used && (rd_addr != '0) &&
          (rec_wa[(k-1)*ADDR_W +: ADDR_W] == rd_addr)) begin
        hit      = 1'b1;
        sel      = SEL_W'(k);
        src      = rec_src[(k-1)*SRC_W +: SRC_W];
        hit_tnew = rec_tnew[(k-1)*TNEW_W +: TNEW_W];
      end
    end
    rdy    = hit ? (hit_tnew == '0) : 1'b1;
    hazard = hit && (hit_tnew > rd_tuse);
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//  Hazard/forwarding controller for the pipelined MIPS core. Tracks in-flight
//  register writes over DEPTH stages (1 = E .. DEPTH = W) with Tnew counters
//  and checks NUM_RD decode read ports (with Tuse) against them.
//  Ports:
//    clk, reset                 rising-edge clock, synchronous active-high reset
//    d_valid/d_wa/d_tnew/d_src  write issued by the D instruction
//    rd_addr/rd_used/rd_tuse    packed read ports, port i at slice i
//    flush                      kill D issue (stage-1 write becomes a bubble)
//    stall                      freeze PC/D, bubble into E
//    fwd_sel/fwd_src/fwd_rdy    per-port bypass select, result kind, ready
//    stall_cnt                  stall cycle counter
//  Configuration macro FWD_STALL_CNT_EN: when defined, stall_cnt counts stalled
//  edges (saturating); otherwise it is tied to zero with no flops.
// ---------------------------------------------------------------------------
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2,
  parameter int SRC_W  = 3,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic [ADDR_W-1:0]        d_wa,
  input  logic [TNEW_W-1:0]        d_tnew,
  input  logic [SRC_W-1:0]         d_src,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_used,
  input  logic [NUM_RD*TNEW_W-1:0] rd_tuse,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_RD*SEL_W-1:0]  fwd_sel,
  output logic [NUM_RD*SRC_W-1:0]  fwd_src,
  output logic [NUM_RD-1:0]        fwd_rdy,
  output logic [31:0]              stall_cnt
);

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  logic [DEPTH-1:0]        rec_vld;
  logic [DEPTH*ADDR_W-1:0] rec_wa;
  logic [DEPTH*TNEW_W-1:0] rec_tnew;
  logic [DEPTH*SRC_W-1:0]  rec_src;
  logic [NUM_RD-1:0]       port_hazard;
  logic                    issue;

  // A write to $0 is never recorded: nothing may forward from it.
  assign issue = d_valid && !stall && !flush && (d_wa != '0);
  assign stall = |port_hazard;

  // ---- Record shift register: D -> stage 1 -> ... -> stage DEPTH (retire) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_vld  <= '0;
      rec_wa   <= '0;
      rec_tnew <= '0;
      rec_src  <= '0;
    end else begin
      rec_vld[0]               <= issue;
      rec_wa[0 +: ADDR_W]      <= issue ? d_wa   : '0;
      rec_tnew[0 +: TNEW_W]    <= issue ? d_tnew : '0;
      rec_src[0 +: SRC_W]      <= issue ? d_src  : '0;
      for (int k = 1; k < DEPTH; k++) begin
        rec_vld[k]                 <= rec_vld[k-1];
        rec_wa[k*ADDR_W +: ADDR_W] <= rec_wa[(k-1)*ADDR_W +: ADDR_W];
        rec_tnew[k*TNEW_W +: TNEW_W] <= tnew_dec(rec_tnew[(k-1)*TNEW_W +: TNEW_W]);
        rec_src[k*SRC_W +: SRC_W]  <= rec_src[(k-1)*SRC_W +: SRC_W];
      end
    end
  end

  // ---- Per-port comparison against the records (combinational) ----
  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    fwd_port_cmp #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .TNEW_W (TNEW_W),
      .SRC_W  (SRC_W),
      .SEL_W  (SEL_W)
    ) u_cmp (
      .rec_vld  (rec_vld),
      .rec_wa   (rec_wa),
      .rec_tnew (rec_tnew),
      .rec_src  (rec_src),
      .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
      .rd_used  (rd_used[i]),
      .rd_tuse  (rd_tuse[i*TNEW_W +: TNEW_W]),
      .sel      (fwd_sel[i*SEL_W +: SEL_W]),
      .src      (fwd_src[i*SRC_W +: SRC_W]),
      .rdy      (fwd_rdy[i]),
      .hazard   (port_hazard[i])
    );
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
  localparam int ADDR_W = 5;
  localparam int TNEW_W = 2;
  localparam int SRC_W  = 3;
  localparam int SEL_W  = 2;

  // Result-kind codes as defined for the core.
  localparam logic [2:0] V  = 3'd0;
  localparam logic [2:0] PC = 3'd1;
  localparam logic [2:0] AO = 3'd2;
  localparam logic [2:0] MD = 3'd3;

`ifdef FWD_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     d_valid;
  logic [ADDR_W-1:0]        d_wa;
  logic [TNEW_W-1:0]        d_tnew;
  logic [SRC_W-1:0]         d_src;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_used;
  logic [NUM_RD*TNEW_W-1:0] rd_tuse;
  logic                     flush;
  logic                     stall;
  logic [NUM_RD*SEL_W-1:0]  fwd_sel;
  logic [NUM_RD*SRC_W-1:0]  fwd_src;
  logic [NUM_RD-1:0]        fwd_rdy;
  logic [31:0]              stall_cnt;

  fwd_scoreboard #(
    .NUM_RD(NUM_RD), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .TNEW_W(TNEW_W), .SRC_W(SRC_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_wa(d_wa),
    .d_tnew(d_tnew), .d_src(d_src), .rd_addr(rd_addr), .rd_used(rd_used),
    .rd_tuse(rd_tuse), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .fwd_src(fwd_src), .fwd_rdy(fwd_rdy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        stall;
    logic [3:0]  sel;
    logic [5:0]  src;
    logic [1:0]  rdy;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, req);
    end
  endtask

  // Monitor: pops the expectation scheduled for this cycle and compares.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: expectation not sampled (cycle %0d, now %0d)",
                 exp_q[0].name, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end else if (exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, "stall",     {31'd0, stall}, {31'd0, e.stall});
        check(e.name, "fwd_sel",   {28'd0, fwd_sel}, {28'd0, e.sel});
        check(e.name, "fwd_src",   {26'd0, fwd_src}, {26'd0, e.src});
        check(e.name, "fwd_rdy",   {30'd0, fwd_rdy}, {30'd0, e.rdy});
        check(e.name, "stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    d_valid = 1'b0; d_wa = '0; d_tnew = '0; d_src = '0;
    rd_addr = '0; rd_used = '0; rd_tuse = '0;
    flush = 1'b0; reset = 1'b0;
  endtask

  task automatic issue(input logic [4:0] wa, input logic [1:0] tn, input logic [2:0] s);
    d_valid = 1'b1; d_wa = wa; d_tnew = tn; d_src = s;
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic u, input logic [1:0] t);
    rd_addr[p*ADDR_W +: ADDR_W] = a;
    rd_used[p]                  = u;
    rd_tuse[p*TNEW_W +: TNEW_W] = t;
  endtask

  task automatic expect_now(input string name, input logic st,
                            input logic [1:0] sel1, input logic [1:0] sel0,
                            input logic [2:0] src1, input logic [2:0] src0,
                            input logic [1:0] rdy, input int cnt);
    exp_t e;
    e.cyc = cyc; e.name = name; e.stall = st;
    e.sel = {sel1, sel0}; e.src = {src1, src0}; e.rdy = rdy;
    e.cnt = CNT_ON ? 32'(cnt) : 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      idle_in();
    end
  endtask

  initial begin
    idle_in();
    reset = 1'b1;

    // 1. reset held two cycles with live inputs
    tick();
    idle_in(); reset = 1'b1; issue(5'd5, 2'd2, MD); rd(0, 5'd5, 1'b1, 2'd0);
    expect_now("reset_hold", 1'b0, 2'd0, 2'd0, V, V, 2'b11, 0);
    tick();
    idle_in();
    expect_now("reset_done", 1'b0, 2'd0, 2'd0, V, V, 2'b11, 0);

    // 2. addu $8 (tnew 1, AO), then read with tuse 1
    tick(); idle_in(); issue(5'd8, 2'd1, AO);
    tick(); idle_in(); rd(0, 5'd8, 1'b1, 2'd1);
    expect_now("addu_s1", 1'b0, 2'd0, 2'd1, V, AO, 2'b10, 0);
    tick(); idle_in(); rd(0, 5'd8, 1'b1, 2'd1);
    expect_now("addu_s2", 1'b0, 2'd0, 2'd2, V, AO, 2'b11, 0);
    idle_n(3);

    // 3. lw $8 (tnew 2, MD), read with tuse 0 -> two stall cycles
    tick(); idle_in(); issue(5'd8, 2'd2, MD);
    tick(); idle_in(); rd(0, 5'd8, 1'b1, 2'd0);
    expect_now("lw_stall1", 1'b1, 2'd0, 2'd1, V, MD, 2'b10, 0);
    tick(); idle_in(); rd(0, 5'd8, 1'b1, 2'd0);
    expect_now("lw_stall2", 1'b1, 2'd0, 2'd2, V, MD, 2'b10, 1);
    tick(); idle_in(); rd(0, 5'd8, 1'b1, 2'd0);
    expect_now("lw_go", 1'b0, 2'd0, 2'd3, V, MD, 2'b11, 2);
    idle_n(3);

    // 4. write $0 then read $0 with tuse 0
    tick(); idle_in(); issue(5'd0, 2'd2, MD);
    tick(); idle_in(); rd(0, 5'd0, 1'b1, 2'd0);
    expect_now("zero_reg", 1'b0, 2'd0, 2'd0, V, V, 2'b11, 2);
    idle_n(3);

    // 5. back-to-back $9 writes, youngest wins; port0 names $9 but is unused
    tick(); idle_in(); issue(5'd9, 2'd0, PC);
    tick(); idle_in(); issue(5'd9, 2'd0, AO);
    tick(); idle_in(); rd(1, 5'd9, 1'b1, 2'd1); rd(0, 5'd9, 1'b0, 2'd0);
    expect_now("youngest", 1'b0, 2'd1, 2'd0, AO, V, 2'b11, 2);
    idle_n(3);

    // 6. stall, then flush + reset together
    tick(); idle_in(); issue(5'd8, 2'd2, MD);
    tick(); idle_in(); rd(0, 5'd8, 1'b1, 2'd0);
    expect_now("pre_rst_stall", 1'b1, 2'd0, 2'd1, V, MD, 2'b10, 2);
    tick(); idle_in(); rd(0, 5'd8, 1'b1, 2'd0); flush = 1'b1; reset = 1'b1;
    expect_now("flush_no_gate", 1'b1, 2'd0, 2'd2, V, MD, 2'b10, 3);
    tick(); idle_in(); rd(0, 5'd8, 1'b1, 2'd0);
    expect_now("post_reset", 1'b0, 2'd0, 2'd0, V, V, 2'b11, 0);

    // flush alone kills the issue
    tick(); idle_in(); issue(5'd10, 2'd2, MD); flush = 1'b1;
    tick(); idle_in(); rd(0, 5'd10, 1'b1, 2'd0);
    expect_now("flush_bubble", 1'b0, 2'd0, 2'd0, V, V, 2'b11, 0);
    idle_n(3);

    // flush during stall: issue on port1's register is dropped
    tick(); idle_in(); issue(5'd11, 2'd2, HL_code());
    tick(); idle_in(); rd(0, 5'd11, 1'b1, 2'd0); issue(5'd12, 2'd0, AO); flush = 1'b1;
    expect_now("flush_in_stall", 1'b1, 2'd0, 2'd1, V, 3'd4, 2'b10, 0);
    tick(); idle_in(); rd(0, 5'd11, 1'b1, 2'd0); rd(1, 5'd12, 1'b1, 2'd0);
    expect_now("after_flush_stall", 1'b1, 2'd0, 2'd2, V, 3'd4, 2'b10, 1);
    tick(); idle_in(); rd(0, 5'd11, 1'b1, 2'd0);
    expect_now("flush_stall_end", 1'b0, 2'd0, 2'd3, V, 3'd4, 2'b11, 2);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  function automatic logic [2:0] HL_code();
    return 3'd4;
  endfunction

endmodule
